// File: rtl/dff_bank_arbiter_if.sv
// Bus between the requesters and the shared-register arbiter.
// Ports:
//   req      per-requester write request (level)
//   data_in  requester i data on bits [i*W +: W]
//   grant    one-hot registered grant
//   q        shared register contents
//   q_valid  one-cycle pulse after q is updated
//   owner    index of the requester that last wrote q
interface dff_bank_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   grant;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [OW-1:0]  owner;

  modport master (output req, data_in, input grant, q, q_valid, owner);
  modport slave  (input req, data_in, output grant, q, q_valid, owner);
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for a shared W-bit register.
// One requester is granted per round; its data is captured on the final
// edge of the grant cycle, then a HOLD_CYCLES cool-down precedes the next
// arbitration.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of dff_bank_arbiter_if (req/data_in in, grant/q/q_valid/owner out)
//
// state | meaning
// IDLE  | waiting for any request; arbitrates when req != 0
// GRANT | one-hot grant asserted for one cycle; capture on its final edge
// HOLD  | cool-down, requests ignored until the counter reaches 1
module dff_bank_arbiter #(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  dff_bank_arbiter_if.slave bus
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t        state;
  logic [OW-1:0] last;
  logic [OW-1:0] cur;
  logic [7:0]    hold_cnt;
  logic [N-1:0]  grant_r;
  logic [W-1:0]  q_r;
  logic          q_valid_r;
  logic [OW-1:0] owner_r;

  logic [OW-1:0] win;
  logic [OW-1:0] cand;
  logic          found;

  // Scan last+1, last+2, ... (mod N); the first active request wins.
  always_comb begin
    win   = last;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = OW'((int'(last) + k) % N);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= OW'(N - 1);
      cur       <= '0;
      hold_cnt  <= '0;
      grant_r   <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
    end else begin
      q_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_r <= {{(N-1){1'b0}}, 1'b1} << win;
            cur     <= win;
            state   <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request aborts the write but still consumes the turn.
          if (bus.req[cur]) begin
            q_r       <= bus.data_in[cur*W +: W];
            owner_r   <= cur;
            q_valid_r <= 1'b1;
          end
          last    <= cur;
          grant_r <= '0;
          if (HOLD_CYCLES == 0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= 8'(HOLD_CYCLES);
            state    <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 8'd1;
          if (hold_cnt == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant   = grant_r;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.owner   = owner_r;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
module tb_dff_bank_arbiter;
  logic clk;
  logic rst;
  logic rst0;

  dff_bank_arbiter_if #(.N(4), .W(8)) bus  ();
  dff_bank_arbiter_if #(.N(4), .W(8)) bus0 ();

  dff_bank_arbiter #(.N(4), .W(8), .HOLD_CYCLES(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  dff_bank_arbiter #(.N(4), .W(8), .HOLD_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // expected captures: {owner[1:0], q[7:0]}
  logic [9:0] exp_q  [$];
  logic [9:0] exp_q0 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard for each instance: every q_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.q_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_q_valid", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("capture_q", 32'(bus.q), 32'(e[7:0]));
        chk("capture_owner", 32'(bus.owner), 32'(e[9:8]));
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.q_valid === 1'b1) begin
      if (exp_q0.size() == 0) begin
        chk("zh_unexpected_q_valid", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q0.pop_front();
        chk("zh_capture_q", 32'(bus0.q), 32'(e[7:0]));
        chk("zh_capture_owner", 32'(bus0.owner), 32'(e[9:8]));
      end
    end
  end

  task automatic wait_grant(input bit sel, input string tag, output int cyc, output logic [3:0] g);
    cyc = 0;
    g   = '0;
    while (g == 4'b0000 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      g = sel ? bus0.grant : bus.grant;
    end
    if (g == 4'b0000) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int         cyc;
    logic [3:0] g;
    logic [7:0] d [4];

    rst  = 1'b1;
    rst0 = 1'b1;
    d[0] = 8'h10; d[1] = 8'h11; d[2] = 8'h12; d[3] = 8'h13;
    bus.req      = 4'b1111;
    bus.data_in  = {d[3], d[2], d[1], d[0]};
    bus0.req     = 4'b0000;
    bus0.data_in = {8'h00, 8'h00, 8'h22, 8'h21};

    // reset held with all requests active
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_q", 32'(bus.q), 32'd0);
      chk("rst_q_valid", 32'(bus.q_valid), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
    end
    rst = 1'b0;

    // fairness: grants 0,1,2,3,0 four cycles apart
    for (int i = 0; i < 5; i++) begin
      wait_grant(1'b0, "fair", cyc, g);
      chk("fair_grant", 32'(g), 32'(4'b0001 << (i % 4)));
      if (i == 0) chk("first_grant_latency", 32'(cyc), 32'd1);
      else        chk("fair_period", 32'(cyc), 32'd4);
      exp_q.push_back({2'(i % 4), d[i % 4]});
    end
    @(negedge clk);
    bus.req = 4'b0000;
    repeat (6) @(negedge clk);
    chk("fair_drain", 32'(exp_q.size()), 32'd0);

    // single requester 2, pointer currently at 0
    d[2] = 8'hA5;
    bus.data_in = {d[3], d[2], d[1], d[0]};
    bus.req     = 4'b0100;
    wait_grant(1'b0, "single", cyc, g);
    chk("single_grant", 32'(g), 32'h4);
    exp_q.push_back({2'd2, 8'hA5});
    @(negedge clk);
    chk("single_grant_one_cycle", 32'(bus.grant), 32'd0);
    wait_grant(1'b0, "single_again", cyc, g);
    chk("single_hold_gap", 32'(cyc), 32'd3);
    exp_q.push_back({2'd2, 8'hA5});
    @(negedge clk);
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    chk("single_drain", 32'(exp_q.size()), 32'd0);

    // abort: requester 1 drops during its grant, requester 2 keeps asking
    d[2] = 8'h5C;
    bus.data_in = {d[3], d[2], d[1], d[0]};
    bus.req     = 4'b0110;
    wait_grant(1'b0, "abort", cyc, g);
    chk("abort_grant1", 32'(g), 32'h2);
    bus.req = 4'b0100;
    @(negedge clk);
    chk("abort_q_unchanged", 32'(bus.q), 32'hA5);
    chk("abort_no_valid", 32'(bus.q_valid), 32'd0);
    chk("abort_owner", 32'(bus.owner), 32'd2);
    wait_grant(1'b0, "after_abort", cyc, g);
    chk("after_abort_grant", 32'(g), 32'h4);
    exp_q.push_back({2'd2, 8'h5C});
    @(negedge clk);
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    chk("abort_drain", 32'(exp_q.size()), 32'd0);

    // reset during the grant of requester 3
    d[3] = 8'h3C;
    bus.data_in = {d[3], d[2], d[1], d[0]};
    bus.req     = 4'b1000;
    wait_grant(1'b0, "mid_rst", cyc, g);
    chk("mid_rst_grant3", 32'(g), 32'h8);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant", 32'(bus.grant), 32'd0);
    chk("mid_rst_q", 32'(bus.q), 32'd0);
    chk("mid_rst_q_valid", 32'(bus.q_valid), 32'd0);
    chk("mid_rst_owner", 32'(bus.owner), 32'd0);
    rst     = 1'b0;
    bus.req = 4'b1001;
    wait_grant(1'b0, "post_rst", cyc, g);
    chk("post_rst_grant", 32'(g), 32'h1);
    exp_q.push_back({2'd0, d[0]});
    @(negedge clk);
    bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    chk("post_rst_drain", 32'(exp_q.size()), 32'd0);

    // zero hold: 0,1,0,1 every two cycles
    rst0     = 1'b0;
    bus0.req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_grant(1'b1, "zh", cyc, g);
      chk("zh_grant", 32'(g), 32'(4'b0001 << (i % 2)));
      if (i == 0) chk("zh_first_latency", 32'(cyc), 32'd1);
      else        chk("zh_period", 32'(cyc), 32'd2);
      exp_q0.push_back({2'(i % 2), (i % 2 == 0) ? 8'h21 : 8'h22});
    end
    @(negedge clk);
    bus0.req = 4'b0000;
    repeat (4) @(negedge clk);
    chk("zh_drain", 32'(exp_q0.size()), 32'd0);
    chk("zh_idle_grant", 32'(bus0.grant), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and write sequencer for a shared W-bit positive-edge D-flip-flop register. Up to N requesters compete for the register. The block grants one requester at a time, captures the granted requester's data into the register, then enforces a programmable hold (cool-down) window before it arbitrates again. It sits between the requesting logic and the shared posedge storage, and it is the only writer of that storage.

## Interface
- N, default 4: number of requesters, 2..16.
- W, default 8: data width of the shared register, 1..64.
- HOLD_CYCLES, default 2: idle cycles after each write before re-arbitration, 0..255.

- clk  input  1  rising-edge clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- req  input  N  per-requester write request; level-sensitive.
- data_in  input  N*W  requester i's data on bits [i*W +: W].
- grant  output  N  one-hot registered grant; all-zero when no grant.
- q  output  W  shared register contents.
- q_valid  output  1  one-cycle pulse, high in the cycle after q is updated.
- owner  output  clog2(N)  index of the requester that last wrote q.

## Operation
- Reset values:
  - grant = 0, q = 0, q_valid = 0, owner = 0.
  - State = IDLE, hold counter = 0.
  - Round-robin pointer last = N-1, so requester 0 has top priority after reset.
- IDLE state:
  - If req == 0, stay in IDLE.
  - Otherwise choose the winner: the first i with req[i]=1, scanning last+1, last+2, ... modulo N.
  - Register grant = one-hot(winner) and go to GRANT.
- GRANT state (exactly one cycle):
  - If req[winner]=1 at the end of the cycle:
    - q <= data_in[winner].
    - owner <= winner.
    - q_valid <= 1.
  - If req[winner]=0 (abort):
    - q and owner are unchanged.
    - q_valid stays 0.
  - In both cases:
    - last <= winner (the pointer advances on abort too).
    - grant <= 0.
    - Load the hold counter with HOLD_CYCLES.
    - Go to HOLD, or to IDLE if HOLD_CYCLES = 0.
- HOLD state:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to IDLE at the next edge.
  - req is ignored here.
- q_valid is cleared in every cycle other than the one that follows a completed capture.
- Requesters hold req and their data stable from request until grant falls. Data is sampled only on the final edge of GRANT.
- Reset has priority over all other events, including reset arriving in GRANT or HOLD. The interrupted write is discarded: q = 0, not the partial value.
- Invariants:
  - grant is at most one-hot.
  - grant is nonzero only in GRANT.
  - q changes only on a completed capture or on reset.

## Timing
- Request-to-grant latency:
  - Request seen in IDLE at edge t.
  - grant is high during cycle t..t+1, for exactly one cycle.
- Grant-to-data latency:
  - q updates at edge t+1.
  - q_valid is high during cycle t+1..t+2.
- Arbitration period under continuous requests is 2 + HOLD_CYCLES cycles: IDLE 1, GRANT 1, HOLD HOLD_CYCLES.
- Worst-case wait for a continuously requesting input is N*(2 + HOLD_CYCLES) cycles.
- owner and q update on the same edge, so they are always consistent.
- The hold counter is 8 bits wide and never wraps, because it is only loaded when HOLD_CYCLES ≥ 1.

## Test plan
All scenarios use N=4, W=8, HOLD_CYCLES=2 unless stated otherwise.

- Reset: rst=1 for 3 cycles with req=4'b1111 -> grant=0, q=8'h00, q_valid=0, owner=0 throughout. The first grant after release is 4'b0001.
- Single requester: req=4'b0100 with data2=8'hA5 -> grant=4'b0100 for one cycle. The next edge gives q=8'hA5, q_valid=1 for one cycle, and owner=2. No further grant for 2 cycles.
- Fairness: req=4'b1111 held with data_i=8'h10+i -> grants 0,1,2,3,0 exactly 4 cycles apart. q takes 8'h10, 11, 12, 13, 10 in that order.
- Abort: req[1] is dropped during its GRANT cycle, with req[2] held -> q unchanged and q_valid=0. The next grant is 4'b0100, not requester 1.
- Reset mid-operation: rst is asserted during GRANT for requester 3 -> the next cycle has grant=0 and q=8'h00. After release with req=4'b1001, the grant goes to requester 0.
- Zero hold: HOLD_CYCLES=0 and req=4'b0011 -> grants alternate 0,1,0,1 every 2 cycles, and q_valid pulses on every second cycle.
